// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign-correction cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] a_raw;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             sgn
    );
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // acc is the product upper half / partial remainder; sh is the
    // multiplier shifting out / dividend shifting out as quotient shifts in
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               sgn_op;

    assign add_sum  = {1'b0, acc} + (sh[0] ? {1'b0, mag_b} : '0);
    assign trial    = {acc, sh[WIDTH-1]};
    assign fits     = trial >= {1'b0, mag_b};
    assign rem_next = fits ? WIDTH'(trial - {1'b0, mag_b})
                           : trial[WIDTH-1:0];
    assign prod     = {acc, sh};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -sh : sh;
    assign r_fix    = neg_r ? -acc : acc;
    assign sgn_op   = ~op[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            mag_b  <= '0;
            acc    <= '0;
            sh     <= '0;
            a_raw  <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        mag_b  <= mag(b, sgn_op);
                        sh     <= mag(a, sgn_op);
                        acc    <= '0;
                        a_raw  <= a;
                        neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= sgn_op & op[1] & a[WIDTH-1];
                        dz     <= op[1] & (b == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc <= rem_next;
                        sh  <= {sh[WIDTH-2:0], fits};
                    end else begin
                        acc <= add_sum[WIDTH:1];
                        sh  <= {add_sum[0], sh[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    unique case (1'b1)
                        dz: begin
                            hi <= a_raw;
                            lo <= '1;
                        end
                        is_div && !dz: begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                        !is_div: begin
                            {hi, lo} <= prod_fix;
                        end
                        default: ;
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops checked against
// a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(
        input  logic [1:0]   o,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        output logic [W-1:0] eh,
        output logic [W-1:0] el
    );
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
        if (!o[1]) begin
            p = 64'(sx * sy);
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 0) begin
            eh = x;
            el = '1;
        end else begin
            el = 32'(sx / sy);
            eh = 32'(sx % sy);
        end
    endfunction

    // Called at #1 after an edge; returns in the done cycle (or on timeout).
    // inj: 0 none, 1 mtlo pulse mid-run, 2 start re-pulse, 3 mthi pulse.
    task automatic run_op(
        input  logic [1:0]   o,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        input  int           inj,
        output int           nb,
        output int           nd,
        output bit           held
    );
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        h0 = hi;
        l0 = lo;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        nb = 0;
        nd = 0;
        held = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                nd = 1;
                break;
            end
            if (busy) nb++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            a = $urandom;
            b = $urandom;
            op = 2'($urandom);
            mtlo = (inj == 1 && i == 5);
            start = (inj == 2 && i == 5);
            mthi = (inj == 3 && i == 7);
            step();
        end
        mtlo = 1'b0;
        mthi = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = 32'hDEAD_BEEF;
        b = 32'h1;
        mthi = 1'b1;
        mtlo = 1'b1;
        step();
        step();
        mthi = 1'b0;
        mtlo = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctl: got busy=%b done=%b need 0 0", busy, done);
        end
        n_checks++;
        if (hi !== 0 || lo !== 0) begin
            n_fail++;
            $display("FAIL reset_hilo: got hi=%h lo=%h need 0 0", hi, lo);
        end
        rst = 1'b0;
        step();
    endtask

    logic [1:0]   d_op [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [W-1:0] d_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9,
                               32'd100, 32'h80000000, 32'd50};
    logic [W-1:0] d_b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2,
                               32'd0, 32'hFFFFFFFF, 32'd7};
    logic [W-1:0] d_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd100, 32'd0, 32'd1};
    logic [W-1:0] d_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'h80000000, 32'd7};

    task automatic test_directed();
        int nb;
        int nd;
        bit held;
        for (int i = 0; i < 6; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 0, nb, nd, held);
            n_checks++;
            if (nb !== 33 || nd !== 1) begin
                n_fail++;
                $display("FAIL dir_timing[%0d]: got busy=%0d done=%0d need 33 1", i, nb, nd);
            end
            n_checks++;
            if (!held) begin
                n_fail++;
                $display("FAIL dir_hold[%0d]: hi/lo changed during run", i);
            end
            n_checks++;
            if (hi !== d_hi[i] || lo !== d_lo[i]) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got %h:%h need %h:%h", i, hi, lo, d_hi[i], d_lo[i]);
            end
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_pulse[%0d]: got done=%b busy=%b need 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] sp [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic [1:0]   o;
        int nb;
        int nd;
        bit held;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(0, 20));
            model(o, x, y, eh, el);
            run_op(o, x, y, 0, nb, nd, held);
            n_checks++;
            if (nd !== 1 || nb !== 33 || hi !== eh || lo !== el) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h:%h (busy=%0d done=%0d) need %h:%h",
                         i, o, x, y, hi, lo, nb, nd, eh, el);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] l0;
        int nb;
        int nd;
        bit held;
        l0 = lo;
        a = 32'h1234;
        mthi = 1'b1;
        step();
        mthi = 1'b0;
        n_checks++;
        if (hi !== 32'h1234 || lo !== l0) begin
            n_fail++;
            $display("FAIL mthi: got %h:%h need 00001234:%h", hi, lo, l0);
        end
        a = 32'h5678;
        mtlo = 1'b1;
        step();
        mtlo = 1'b0;
        n_checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++;
            $display("FAIL mtlo: got %h:%h need 00001234:00005678", hi, lo);
        end
        a = 32'h9ABC;
        mthi = 1'b1;
        mtlo = 1'b1;
        step();
        mthi = 1'b0;
        mtlo = 1'b0;
        n_checks++;
        if (hi !== 32'h9ABC || lo !== 32'h9ABC) begin
            n_fail++;
            $display("FAIL mt_both: got %h:%h need 00009abc:00009abc", hi, lo);
        end
        mthi = 1'b1;
        mtlo = 1'b1;
        run_op(2'd1, 32'd2, 32'd2, 3, nb, nd, held);
        n_checks++;
        if (!held || hi !== 0 || lo !== 4) begin
            n_fail++;
            $display("FAIL mt_with_start: got %h:%h held=%b need 0:4 held=1", hi, lo, held);
        end
        step();
        run_op(2'd1, 32'd3, 32'd5, 1, nb, nd, held);
        n_checks++;
        if (!held || hi !== 0 || lo !== 15) begin
            n_fail++;
            $display("FAIL mtlo_busy: got %h:%h held=%b need 0:f held=1", hi, lo, held);
        end
        step();
        run_op(2'd1, 32'd3, 32'd5, 2, nb, nd, held);
        n_checks++;
        if (nb !== 33 || nd !== 1 || lo !== 15) begin
            n_fail++;
            $display("FAIL restart_busy: got busy=%0d done=%0d lo=%h need 33 1 f", nb, nd, lo);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_once: got done=%b busy=%b need 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        int nd;
        bit held;
        a = 32'hDEAD;
        mthi = 1'b1;
        mtlo = 1'b1;
        step();
        mthi = 1'b0;
        mtlo = 1'b0;
        op = 2'd3;
        a = 32'd50;
        b = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 0 || lo !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b done=%b %h:%h need 0 0 0:0", busy, done, hi, lo);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got busy=%b done=%b need 0 0", busy, done);
        end
        run_op(2'd3, 32'd50, 32'd7, 0, nb, nd, held);
        n_checks++;
        if (nb !== 33 || nd !== 1 || hi !== 1 || lo !== 7) begin
            n_fail++;
            $display("FAIL rst_fresh: got %h:%h busy=%0d done=%0d need 1:7 33 1", hi, lo, nb, nd);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        int nd;
        bit held;
        run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, nb, nd, held);
        n_checks++;
        if (nd !== 1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            n_fail++;
            $display("FAIL b2b_first: got %h:%h done=%0d need ffffffff:ffffffeb 1", hi, lo, nd);
        end
        run_op(2'd1, 32'd2, 32'd3, 0, nb, nd, held);
        n_checks++;
        if (nb !== 33 || nd !== 1 || !held || hi !== 0 || lo !== 6) begin
            n_fail++;
            $display("FAIL b2b_second: got %h:%h busy=%0d done=%0d held=%b need 0:6 33 1 1",
                     hi, lo, nb, nd, held);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
